mmio_controller: RTL and testbench

- Memory-mapped I/O responder for the Riscv151 core.
- The core's datapath initiates loads and stores. When the upper address nibble selects I/O space (0x8), mem_control routes the access here instead of to bios/imem/dmem.
- The block decodes the address, drives the on-chip uart's ready/valid ports, and keeps cycle and instruction counters.
- Read data returns with the same 1-cycle latency as the block RAMs, so the existing load path muxes it in unchanged.

---
 rtl/mmio_defines.sv | 18 +
 rtl/mmio_counters.sv | 34 +++
 rtl/mmio_controller.sv | 118 +++++++++++
 tb/tb_mmio_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_defines.sv
// rtl/mmio_defines.sv - shared I/O space constants and tx state encoding
package mmio_defines;

    localparam logic [3:0] IO_BASE_NIBBLE = 4'h8;

    localparam logic [7:0] UART_CTRL = 8'h00;
    localparam logic [7:0] UART_RX   = 8'h04;
    localparam logic [7:0] UART_TX   = 8'h08;
    localparam logic [7:0] CYCLE_CNT = 8'h10;
    localparam logic [7:0] INSTR_CNT = 8'h14;
    localparam logic [7:0] CNT_RST   = 8'h18;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_PEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/mmio_counters.sv
// rtl/mmio_counters.sv - free-running cycle counter and retired-instruction counter
module mmio_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             instr_retired,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instr_q;

    // Clear wins over increment; both counters wrap naturally at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_q + ONE;
            if (instr_retired) begin
                instr_q <= instr_q + ONE;
            end
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;

endmodule

// File: rtl/mmio_controller.sv
// rtl/mmio_controller.sv - I/O space responder: uart ports, counters, registered read data
module mmio_controller
    import mmio_defines::*;
#(
    parameter logic [31:0] IO_BASE = 32'h8000_0000,
    parameter int          CNT_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_sel,
    input  logic [31:0] io_adr,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_wea,
    input  logic        io_re,
    input  logic        instr_retired,
    output logic [31:0] io_rdata,
    output logic [7:0]  uart_data_in,
    output logic        uart_data_in_valid,
    input  logic        uart_data_in_ready,
    input  logic [7:0]  uart_data_out,
    input  logic        uart_data_out_valid,
    output logic        uart_data_out_ready
);

    logic [7:0]       offset;
    logic             store;
    logic             load;
    logic             tx_store;
    logic             cnt_clear;
    logic             tx_ready;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;
    logic [31:0]      rdata_d;
    tx_state_e        tx_state_q;
    tx_state_e        tx_state_d;
    logic [7:0]       tx_buf_q;
    logic [7:0]       tx_buf_d;
    logic             unused_bits;

    // Upper address bits are already qualified by io_sel upstream.
    assign unused_bits = ^{io_adr[31:8], io_wdata[31:8], io_wea[3:1]};

    assign offset    = io_adr[7:0] - IO_BASE[7:0];
    assign store     = io_sel & (|io_wea);
    assign load      = io_sel & io_re & ~store;
    assign tx_store  = store & io_wea[0] & (offset == UART_TX);
    assign cnt_clear = store & (offset == CNT_RST);
    assign tx_ready  = (tx_state_q == TX_IDLE);

    assign uart_data_out_ready = ~rst & load & (offset == UART_RX) & uart_data_out_valid;
    assign uart_data_in        = tx_buf_q;
    assign uart_data_in_valid  = (tx_state_q == TX_PEND);

    mmio_counters #(
        .CNT_W(CNT_W)
    ) u_counters (
        .clk          (clk),
        .rst          (rst),
        .clear        (cnt_clear),
        .instr_retired(instr_retired),
        .cycle_cnt    (cycle_cnt),
        .instr_cnt    (instr_cnt)
    );

    // Tx state register and byte buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_buf_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_buf_q   <= tx_buf_d;
        end
    end

    // Tx next state: only an idle transmitter accepts a new byte, so stores
    // while pending (including the handshake cycle) are dropped.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_buf_d   = tx_buf_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_store) begin
                    tx_state_d = TX_PEND;
                    tx_buf_d   = io_wdata[7:0];
                end
            end
            TX_PEND: begin
                if (uart_data_in_ready) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Read mux; unmapped and write-only offsets read as zero.
    always_comb begin
        rdata_d = '0;
        case (offset)
            UART_CTRL: rdata_d = {30'b0, uart_data_out_valid, tx_ready};
            UART_RX:   rdata_d = uart_data_out_valid ? {24'b0, uart_data_out} : 32'b0;
            CYCLE_CNT: rdata_d = 32'(cycle_cnt);
            INSTR_CNT: rdata_d = 32'(instr_cnt);
            default:   rdata_d = '0;
        endcase
    end

    // Load data lands one cycle after the load, matching block RAM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_rdata <= '0;
        end else if (load) begin
            io_rdata <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mmio_controller.sv
// tb/tb_mmio_controller.sv - self-checking bench for mmio_controller
module tb_mmio_controller;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_sel;
    logic [31:0] io_adr;
    logic [31:0] io_wdata;
    logic [3:0]  io_wea;
    logic        io_re;
    logic        instr_retired;
    logic [31:0] io_rdata;
    logic [7:0]  uart_data_in;
    logic        uart_data_in_valid;
    logic        uart_data_in_ready;
    logic [7:0]  uart_data_out;
    logic        uart_data_out_valid;
    logic        uart_data_out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    logic chk_d = 1'b0;

    typedef struct {
        logic [7:0]  off;
        logic        rx_v;
        logic [7:0]  rx_d;
        logic [31:0] exp_rdata;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    mmio_controller dut (
        .clk                (clk),
        .rst                (rst),
        .io_sel             (io_sel),
        .io_adr             (io_adr),
        .io_wdata           (io_wdata),
        .io_wea             (io_wea),
        .io_re              (io_re),
        .instr_retired      (instr_retired),
        .io_rdata           (io_rdata),
        .uart_data_in       (uart_data_in),
        .uart_data_in_valid (uart_data_in_valid),
        .uart_data_in_ready (uart_data_in_ready),
        .uart_data_out      (uart_data_out),
        .uart_data_out_valid(uart_data_out_valid),
        .uart_data_out_ready(uart_data_out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A qualified load sampled at a posedge produces io_rdata by the next negedge.
    always @(posedge clk) chk_d <= io_sel && io_re && (io_wea == 4'b0) && !rst;

    always @(negedge clk) begin
        if (chk_d) begin
            if (exp_q.size() == 0) begin
                check("rdata_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, io_rdata, e.value);
            end
        end
    end

    task automatic set_idle();
        io_sel        = 1'b0;
        io_adr        = '0;
        io_wdata      = '0;
        io_wea        = '0;
        io_re         = 1'b0;
        instr_retired = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        set_idle();
    endtask

    task automatic drive_load(input logic [7:0] off, input string name, input logic [31:0] exp);
        exp_t e;
        io_sel   = 1'b1;
        io_re    = 1'b1;
        io_adr   = BASE | {24'b0, off};
        e.name   = name;
        e.value  = exp;
        exp_q.push_back(e);
    endtask

    task automatic drive_store(input logic [7:0] off, input logic [31:0] data, input logic [3:0] wea);
        io_sel   = 1'b1;
        io_adr   = BASE | {24'b0, off};
        io_wdata = data;
        io_wea   = wea;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h00, 1'b1, 8'h5A, 32'h0000_0003, 1'b0};
        vecs[1] = '{8'h04, 1'b1, 8'h5A, 32'h0000_005A, 1'b1};
        vecs[2] = '{8'h0C, 1'b1, 8'h5A, 32'h0000_0000, 1'b0};
        vecs[3] = '{8'h08, 1'b1, 8'h5A, 32'h0000_0000, 1'b0};
        vecs[4] = '{8'h1C, 1'b1, 8'hC3, 32'h0000_0000, 1'b0};
        vecs[5] = '{8'h04, 1'b1, 8'hC3, 32'h0000_00C3, 1'b1};
        vecs[6] = '{8'h04, 1'b0, 8'h77, 32'h0000_0000, 1'b0};
        vecs[7] = '{8'h00, 1'b0, 8'h77, 32'h0000_0001, 1'b0};

        rst                 = 1'b1;
        uart_data_in_ready  = 1'b0;
        uart_data_out       = '0;
        uart_data_out_valid = 1'b0;
        set_idle();

        // Reset held two cycles.
        repeat (2) @(negedge clk);
        check("reset_rdata", io_rdata, 32'h0);
        check("reset_tx_valid", {31'b0, uart_data_in_valid}, 32'h0);
        check("reset_rx_ready", {31'b0, uart_data_out_ready}, 32'h0);
        rst = 1'b0;
        drive_load(8'h10, "first_cycle_cnt", 32'h0);

        // Five retired instructions over twenty cycles.
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            instr_retired = (i % 4 == 0);
        end
        next_cycle();
        drive_load(8'h14, "instr_cnt_5", 32'd5);

        // Table of single-cycle reads with rx inputs and pop strobe.
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            uart_data_out_valid = vecs[i].rx_v;
            uart_data_out       = vecs[i].rx_d;
            drive_load(vecs[i].off, $sformatf("vec%0d_rdata", i), vecs[i].exp_rdata);
            #1;
            check($sformatf("vec%0d_pop", i), {31'b0, uart_data_out_ready}, {31'b0, vecs[i].exp_ready});
        end

        // Pop is a single-cycle pulse even while rx valid stays high.
        next_cycle();
        uart_data_out_valid = 1'b1;
        uart_data_out       = 8'h5A;
        drive_load(8'h04, "rx_pop_rdata", 32'h5A);
        #1;
        check("rx_pop_pulse", {31'b0, uart_data_out_ready}, 32'h1);
        next_cycle();
        #1;
        check("rx_pop_after", {31'b0, uart_data_out_ready}, 32'h0);
        uart_data_out_valid = 1'b0;

        // Tx backpressure: byte held, status busy, second store dropped.
        next_cycle();
        drive_store(8'h08, 32'h0000_0041, 4'b0001);
        next_cycle();
        check("tx_valid_c1", {31'b0, uart_data_in_valid}, 32'h1);
        check("tx_data_c1", {24'b0, uart_data_in}, 32'h41);
        drive_load(8'h00, "status_busy", 32'h0);
        next_cycle();
        check("tx_valid_c2", {31'b0, uart_data_in_valid}, 32'h1);
        drive_store(8'h08, 32'h0000_0042, 4'b0001);
        next_cycle();
        check("tx_data_c3", {24'b0, uart_data_in}, 32'h41);
        next_cycle();
        check("tx_valid_c4", {31'b0, uart_data_in_valid}, 32'h1);
        check("tx_data_drop", {24'b0, uart_data_in}, 32'h41);
        uart_data_in_ready = 1'b1;
        drive_store(8'h08, 32'h0000_0043, 4'b0001);
        next_cycle();
        uart_data_in_ready = 1'b0;
        check("tx_valid_drop", {31'b0, uart_data_in_valid}, 32'h0);
        drive_load(8'h00, "status_ready", 32'h1);
        next_cycle();
        check("tx_handshake_store_drop", {31'b0, uart_data_in_valid}, 32'h0);

        // Reset mid-pending abandons the byte.
        drive_store(8'h08, 32'h0000_0055, 4'b1111);
        next_cycle();
        check("tx_pend_before_rst", {31'b0, uart_data_in_valid}, 32'h1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check("tx_valid_after_rst", {31'b0, uart_data_in_valid}, 32'h0);
        check("tx_buf_after_rst", {24'b0, uart_data_in}, 32'h0);

        // Qualification: io_sel low, and wrong byte lane.
        next_cycle();
        io_adr   = BASE | 32'h08;
        io_wdata = 32'h66;
        io_wea   = 4'b0001;
        next_cycle();
        check("no_sel_no_tx", {31'b0, uart_data_in_valid}, 32'h0);
        drive_store(8'h08, 32'h0000_6666, 4'b0010);
        next_cycle();
        check("wea1_no_tx", {31'b0, uart_data_in_valid}, 32'h0);

        // Counter clear beats a simultaneous retirement.
        drive_store(8'h18, 32'hDEAD_BEEF, 4'b1111);
        instr_retired = 1'b1;
        next_cycle();
        drive_load(8'h10, "cycle_after_clear", 32'h0);
        next_cycle();
        drive_load(8'h14, "instr_after_clear", 32'h0);
        repeat (3) next_cycle();
        next_cycle();
        drive_load(8'h10, "cycle_5_after_clear", 32'd5);

        // Wrap from all-ones.
        next_cycle();
        force dut.u_counters.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_counters.cycle_q;
        drive_load(8'h10, "cycle_all_ones", 32'hFFFF_FFFF);
        next_cycle();
        drive_load(8'h10, "cycle_wrapped", 32'h0);

        repeat (3) next_cycle();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
